multdiv_unit: RTL and testbench

Iterative signed 32-bit multiply/divide unit for the execute stage of the pipelined processor. It serves the R-type `mul` (ALU_op 00110) and `div` (ALU_op 00111) instructions. The decode logic asserts a one-cycle start pulse; this block latches operands, iterates, and returns a one-cycle ready pulse with result and exception. While busy, the pipeline stalls, and the exception bit is written to the status register $r30.

---
 rtl/multdiv_unit.sv | 152 +++++++++++++++
 tb/tb_multdiv_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_unit.sv
// Iterative signed 32-bit multiply/divide: shift-add multiply, restoring divide,
// 33-cycle start-to-ready latency with a one-cycle ready pulse.
module multdiv_unit (
   input  logic        clock,
   input  logic        reset,
   input  logic        ctrl_MULT,
   input  logic        ctrl_DIV,
   input  logic [31:0] data_operandA,
   input  logic [31:0] data_operandB,
   output logic [31:0] data_result,
   output logic        data_exception,
   output logic        data_resultRDY,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, DONE} state_t;

   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [63:0] acc_q, acc_d;
   logic [31:0] opnd_q, opnd_d;
   logic        sign_q, sign_d;
   logic        divz_q, divz_d;
   logic        dovf_q, dovf_d;
   logic [31:0] res_q, res_d;
   logic        exc_q, exc_d;
   logic        rdy_q, rdy_d;
   logic        busy_q, busy_d;

   // Magnitudes are unsigned, so |0x80000000| stays 0x80000000.
   logic [31:0] mag_a, mag_b;
   assign mag_a = data_operandA[31] ? (~data_operandA + 32'd1) : data_operandA;
   assign mag_b = data_operandB[31] ? (~data_operandB + 32'd1) : data_operandB;

   // Multiply step: acc = {partial product, remaining multiplier bits}.
   logic [31:0] mul_add;
   logic [32:0] mul_sum;
   logic [63:0] mul_nxt;
   assign mul_add = acc_q[0] ? opnd_q : 32'd0;
   assign mul_sum = {1'b0, acc_q[63:32]} + {1'b0, mul_add};
   assign mul_nxt = {mul_sum, acc_q[31:1]};

   // Divide step: acc = {remainder, dividend bits shifting into quotient}.
   logic [32:0] div_tmp;
   logic [31:0] div_sub;
   logic        div_geq;
   logic [63:0] div_nxt;
   assign div_tmp = {acc_q[63:32], acc_q[31]};
   assign div_geq = div_tmp >= {1'b0, opnd_q};
   assign div_sub = div_tmp[31:0] - opnd_q;
   assign div_nxt = div_geq ? {div_sub, acc_q[30:0], 1'b1}
                            : {div_tmp[31:0], acc_q[30:0], 1'b0};

   logic [63:0] prod_s;
   logic [31:0] quo_s;
   logic        mul_ovf;
   assign prod_s  = sign_q ? (~acc_q + 64'd1) : acc_q;
   assign quo_s   = sign_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
   assign mul_ovf = ~((&prod_s[63:31]) | ~(|prod_s[63:31]));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      opnd_d  = opnd_q;
      sign_d  = sign_q;
      divz_d  = divz_q;
      dovf_d  = dovf_q;
      res_d   = res_q;
      exc_d   = exc_q;
      rdy_d   = 1'b0;

      case (state_q)
         MUL_RUN: begin
            if (cnt_q == 6'd32) begin
               state_d = DONE;
               rdy_d   = 1'b1;
               res_d   = prod_s[31:0];
               exc_d   = mul_ovf;
            end else begin
               acc_d = mul_nxt;
               cnt_d = cnt_q + 6'd1;
            end
         end
         DIV_RUN: begin
            if (cnt_q == 6'd32) begin
               state_d = DONE;
               rdy_d   = 1'b1;
               res_d   = divz_q ? 32'd0 : quo_s;
               exc_d   = divz_q | dovf_q;
            end else begin
               acc_d = div_nxt;
               cnt_d = cnt_q + 6'd1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // A start in any state restarts; the abandoned operation never reports.
      if (ctrl_MULT || ctrl_DIV) begin
         state_d = ctrl_MULT ? MUL_RUN : DIV_RUN;
         cnt_d   = 6'd0;
         sign_d  = data_operandA[31] ^ data_operandB[31];
         opnd_d  = ctrl_MULT ? mag_a : mag_b;
         acc_d   = {32'd0, ctrl_MULT ? mag_b : mag_a};
         divz_d  = ~ctrl_MULT & (data_operandB == 32'd0);
         dovf_d  = ~ctrl_MULT & (data_operandA == 32'h8000_0000)
                              & (data_operandB == 32'hFFFF_FFFF);
         res_d   = res_q;
         exc_d   = exc_q;
         rdy_d   = 1'b0;
      end
   end

   // Stall rises the edge after acceptance and drops when leaving DONE.
   assign busy_d = (state_q != IDLE) && (state_d != IDLE);

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= 6'd0;
         acc_q   <= 64'd0;
         opnd_q  <= 32'd0;
         sign_q  <= 1'b0;
         divz_q  <= 1'b0;
         dovf_q  <= 1'b0;
         res_q   <= 32'd0;
         exc_q   <= 1'b0;
         rdy_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         opnd_q  <= opnd_d;
         sign_q  <= sign_d;
         divz_q  <= divz_d;
         dovf_q  <= dovf_d;
         res_q   <= res_d;
         exc_q   <= exc_d;
         rdy_q   <= rdy_d;
         busy_q  <= busy_d;
      end
   end

   assign data_result    = res_q;
   assign data_exception = exc_q;
   assign data_resultRDY = rdy_q;
   assign busy           = busy_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// Bench for multdiv_unit: vector table plus random vectors through a scoreboard,
// and hand-written restart / reset / back-to-back sequences.
module tb_multdiv_unit;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        ctrl_MULT = 1'b0;
   logic        ctrl_DIV = 1'b0;
   logic [31:0] data_operandA = 32'd0;
   logic [31:0] data_operandB = 32'd0;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_resultRDY;
   logic        busy;

   multdiv_unit dut (
      .clock          (clock),
      .reset          (reset),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY),
      .busy           (busy)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] r;
      logic        e;
      string       name;
   } exp_t;

   typedef struct {
      bit          is_div;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
      logic        e;
      string       name;
   } vec_t;

   exp_t sbq[$];
   int   checks = 0;
   int   failures = 0;
   int   rdy_cnt = 0;

   task automatic check(string name, logic [63:0] got, logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, got, exp);
      end
   endtask

   function automatic void model(bit is_div, logic [31:0] a, logic [31:0] b,
                                 output logic [31:0] r, output logic e);
      longint      p;
      logic [63:0] pu;
      int          q;
      if (!is_div) begin
         p  = longint'($signed(a)) * longint'($signed(b));
         pu = p;
         r  = pu[31:0];
         e  = !(pu[63:31] == 33'd0 || pu[63:31] == 33'h1_FFFF_FFFF);
      end else if (b == 32'd0) begin
         r = 32'd0;
         e = 1'b1;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         r = 32'h8000_0000;
         e = 1'b1;
      end else begin
         q = $signed(a) / $signed(b);
         r = q;
         e = 1'b0;
      end
   endfunction

   // Scoreboard: every ready pulse must match the oldest pending expectation.
   always @(negedge clock) begin : mon
      exp_t x;
      if (data_resultRDY === 1'b1) begin
         rdy_cnt++;
         if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_rdy actual=1 required=0");
         end else begin
            x = sbq.pop_front();
            check({x.name, "_res"}, 64'(data_result), 64'(x.r));
            check({x.name, "_exc"}, 64'(data_exception), 64'(x.e));
         end
      end
   end

   // Called at a negedge; the start is sampled on the following posedge (E0).
   task automatic start_op(bit is_div, logic [31:0] a, logic [31:0] b, bit push,
                           logic [31:0] r, logic e, string name);
      exp_t x;
      ctrl_MULT     = !is_div;
      ctrl_DIV      = is_div;
      data_operandA = a;
      data_operandB = b;
      if (push) begin
         x.r = r; x.e = e; x.name = name;
         sbq.push_back(x);
      end
      @(negedge clock);
      ctrl_MULT = 1'b0;
      ctrl_DIV  = 1'b0;
   endtask

   task automatic wait_rdy(string name, bit chk_idle);
      int n = 0;
      while (data_resultRDY !== 1'b1 && n < 60) begin
         @(negedge clock);
         n++;
      end
      check({name, "_latency"}, 64'(n), 64'd33);
      check({name, "_busy_hi"}, 64'(busy), 64'd1);
      if (chk_idle) begin
         @(negedge clock);
         check({name, "_rdy_drop"}, 64'(data_resultRDY), 64'd0);
         check({name, "_busy_drop"}, 64'(busy), 64'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        tbl[10];
      logic [31:0] a, b, r;
      logic        e;
      int          base;

      tbl[0] = '{0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, "mul_7_m3"};
      tbl[1] = '{0, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1'b1, "mul_ovf"};
      tbl[2] = '{0, 32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0, "mul_min_1"};
      tbl[3] = '{0, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "mul_min_m1"};
      tbl[4] = '{0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "mul_m1_m1"};
      tbl[5] = '{1, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0, "div_m7_2"};
      tbl[6] = '{1, 32'd5,          32'd0,         32'h0000_0000, 1'b1, "div_by0"};
      tbl[7] = '{1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "div_ovf"};
      tbl[8] = '{1, 32'h8000_0000,  32'd2,         32'hC000_0000, 1'b0, "div_min_2"};
      tbl[9] = '{1, 32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0, "div_100_m7"};

      // Reset held for two edges
      reset = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("rst_result", 64'(data_result), 64'd0);
      check("rst_exc", 64'(data_exception), 64'd0);
      check("rst_rdy", 64'(data_resultRDY), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      reset = 1'b1;
      @(negedge clock);
      check("rel_rdy", 64'(data_resultRDY), 64'd0);
      check("rel_busy", 64'(busy), 64'd0);

      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         start_op(tbl[i].is_div, tbl[i].a, tbl[i].b, 1'b1, tbl[i].r, tbl[i].e, tbl[i].name);
         wait_rdy(tbl[i].name, 1'b1);
      end

      for (int i = 0; i < 8; i++) begin
         a = $urandom;
         b = (i % 2 == 1) ? ($urandom >> $urandom_range(0, 28)) : ($urandom >> $urandom_range(0, 16));
         if ($urandom_range(0, 1) == 1) b = ~b + 32'd1;
         if (i % 4 == 3) a = a >> 16;
         model(i % 2 == 1, a, b, r, e);
         @(negedge clock);
         start_op(i % 2 == 1, a, b, 1'b1, r, e, "rand");
         wait_rdy("rand", 1'b1);
      end

      // Both starts together: multiply wins
      @(negedge clock);
      ctrl_MULT = 1'b1; ctrl_DIV = 1'b1;
      data_operandA = 32'd6; data_operandB = 32'd3;
      sbq.push_back('{32'd18, 1'b0, "both_start"});
      @(negedge clock);
      ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
      wait_rdy("both_start", 1'b1);

      // Restart at E10 with a divide: only the divide reports
      @(negedge clock);
      base = rdy_cnt;
      start_op(1'b0, 32'd3, 32'd4, 1'b0, 32'd0, 1'b0, "");
      repeat (9) @(negedge clock);
      start_op(1'b1, 32'd100, 32'd7, 1'b1, 32'd14, 1'b0, "restart");
      wait_rdy("restart", 1'b1);
      repeat (40) @(negedge clock);
      check("restart_one_rdy", 64'(rdy_cnt - base), 64'd1);

      // Reset sampled at E20 of a multiply
      @(negedge clock);
      base = rdy_cnt;
      start_op(1'b0, 32'd7, 32'hFFFF_FFFD, 1'b0, 32'd0, 1'b0, "");
      repeat (19) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      check("midrst_result", 64'(data_result), 64'd0);
      check("midrst_exc", 64'(data_exception), 64'd0);
      check("midrst_rdy", 64'(data_resultRDY), 64'd0);
      check("midrst_busy", 64'(busy), 64'd0);
      repeat (40) @(negedge clock);
      check("midrst_no_rdy", 64'(rdy_cnt - base), 64'd0);
      start_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 1'b0, "after_rst");
      wait_rdy("after_rst", 1'b1);

      // Back-to-back: second start sampled on the edge that ends the ready pulse
      @(negedge clock);
      model(1'b0, 32'd12345, 32'hFFFF_FD5A, r, e);
      start_op(1'b0, 32'd12345, 32'hFFFF_FD5A, 1'b1, r, e, "b2b_a");
      wait_rdy("b2b_a", 1'b0);
      start_op(1'b1, 32'hFFFF_0000, 32'd3, 1'b1, 32'hFFFF_AAAB, 1'b0, "b2b_b");
      check("b2b_rdy_drop", 64'(data_resultRDY), 64'd0);
      check("b2b_busy_hold", 64'(busy), 64'd1);
      wait_rdy("b2b_b", 1'b1);

      repeat (5) @(negedge clock);
      check("sb_empty", 64'(sbq.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
